// File: rtl/traffic_light_ctrl.sv
// Two-direction traffic light phase sequencer with a 1 s prescaler and a pedestrian request.
// Build option: define NIGHT_MODE_EN to add the night input and the flashing-yellow NIGHT state.
module traffic_light_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int GREEN_S    = 20,
  parameter int YELLOW_S   = 3,
  parameter int RED_CLR_S  = 1,
  parameter int PED_LEFT_S = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_flag,
`ifdef NIGHT_MODE_EN
  input  logic        night,
`endif
  output logic [2:0]  ns_light,
  output logic [2:0]  ew_light,
  output logic [13:0] dat,
  output logic        pos
);

  // state     | meaning
  // ALL_RED_A | clearance before NS green
  // NS_GREEN  | NS go, EW stop
  // NS_YELLOW | NS stopping
  // ALL_RED_B | clearance before EW green
  // EW_GREEN  | EW go, NS stop
  // EW_YELLOW | EW stopping
  // NIGHT     | both yellows flashing (NIGHT_MODE_EN only)
  typedef enum logic [2:0] {
    ALL_RED_A = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALL_RED_B = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5
`ifdef NIGHT_MODE_EN
    , NIGHT   = 3'd6
`endif
  } state_t;

  localparam logic [2:0]  LAMP_R  = 3'b100;
  localparam logic [2:0]  LAMP_Y  = 3'b010;
  localparam logic [2:0]  LAMP_G  = 3'b001;
  localparam logic [7:0]  DUR_G   = 8'(GREEN_S);
  localparam logic [7:0]  DUR_Y   = 8'(YELLOW_S);
  localparam logic [7:0]  DUR_R   = 8'(RED_CLR_S);
  localparam logic [7:0]  PED_L   = 8'(PED_LEFT_S);
  localparam logic [31:0] TICK_TC = 32'(TICK_DIV - 1);

  state_t      state_q, state_nx, succ;
  logic [7:0]  remain_q, remain_nx;
  logic        ped_q, ped_nx;
  logic [31:0] tick_cnt;
  logic        tick, legal, green;
  logic [2:0]  ns_nx, ew_nx;
  logic        pos_nx;
`ifdef NIGHT_MODE_EN
  logic        flash_q, flash_nx;
`endif

  assign tick = (tick_cnt == TICK_TC);

  function automatic logic [7:0] dur_of(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   dur_of = DUR_G;
      NS_YELLOW, EW_YELLOW: dur_of = DUR_Y;
      default:              dur_of = DUR_R;
    endcase
  endfunction

  always_comb begin
    state_nx  = state_q;
    remain_nx = remain_q;
    succ      = ALL_RED_A;
    legal     = 1'b1;
    green     = 1'b0;
`ifdef NIGHT_MODE_EN
    flash_nx  = flash_q;
`endif
    case (state_q)
      ALL_RED_A: succ = NS_GREEN;
      NS_GREEN:  begin succ = NS_YELLOW; green = 1'b1; end
      NS_YELLOW: succ = ALL_RED_B;
      ALL_RED_B: succ = EW_GREEN;
      EW_GREEN:  begin succ = EW_YELLOW; green = 1'b1; end
      EW_YELLOW: succ = ALL_RED_A;
`ifdef NIGHT_MODE_EN
      NIGHT:     succ = ALL_RED_A;
`endif
      default:   legal = 1'b0;
    endcase

    if (!legal) begin
      state_nx  = ALL_RED_A;
      remain_nx = DUR_R;
    end
`ifdef NIGHT_MODE_EN
    else if (tick && night) begin
      // yellows come on at entry, then toggle on every later tick
      state_nx  = NIGHT;
      remain_nx = 8'd0;
      flash_nx  = (state_q == NIGHT) ? ~flash_q : 1'b1;
    end else if (state_q == NIGHT) begin
      if (tick) begin
        state_nx  = ALL_RED_A;
        remain_nx = DUR_R;
      end
    end
`endif
    else if (tick) begin
      if (remain_q == 8'd1) begin
        state_nx  = succ;
        remain_nx = dur_of(succ);
      end else if (green && ped_q && (remain_q > PED_L)) begin
        remain_nx = PED_L;
      end else begin
        remain_nx = remain_q - 8'd1;
      end
    end

    // clearing at yellow entry takes priority over a simultaneous key
    if ((state_nx == NS_YELLOW && state_q != NS_YELLOW) ||
        (state_nx == EW_YELLOW && state_q != EW_YELLOW))
      ped_nx = 1'b0;
`ifdef NIGHT_MODE_EN
    else if (state_nx == NIGHT)
      ped_nx = 1'b0;
`endif
    else if (key_flag)
      ped_nx = 1'b1;
    else
      ped_nx = ped_q;

    ns_nx  = LAMP_R;
    ew_nx  = LAMP_R;
    pos_nx = 1'b1;
    case (state_nx)
      ALL_RED_A: pos_nx = 1'b0;
      NS_GREEN:  begin ns_nx = LAMP_G; pos_nx = 1'b0; end
      NS_YELLOW: begin ns_nx = LAMP_Y; pos_nx = 1'b0; end
      EW_GREEN:  ew_nx = LAMP_G;
      EW_YELLOW: ew_nx = LAMP_Y;
`ifdef NIGHT_MODE_EN
      NIGHT: begin
        ns_nx  = {1'b0, flash_nx, 1'b0};
        ew_nx  = {1'b0, flash_nx, 1'b0};
        pos_nx = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= 32'd0;
      state_q  <= ALL_RED_A;
      remain_q <= DUR_R;
      ped_q    <= 1'b0;
      ns_light <= LAMP_R;
      ew_light <= LAMP_R;
      dat      <= {6'd0, DUR_R};
      pos      <= 1'b0;
`ifdef NIGHT_MODE_EN
      flash_q  <= 1'b0;
`endif
    end else begin
      tick_cnt <= tick ? 32'd0 : tick_cnt + 32'd1;
      state_q  <= state_nx;
      remain_q <= remain_nx;
      ped_q    <= ped_nx;
      ns_light <= ns_nx;
      ew_light <= ew_nx;
      dat      <= {6'd0, remain_nx};
      pos      <= pos_nx;
`ifdef NIGHT_MODE_EN
      flash_q  <= flash_nx;
`endif
    end
  end

endmodule
